gsx_input_filter: RTL
=====================

# gsx_input_filter

Consumes the parallel receive vector produced by the SGPIO serial-expander master and turns it into a frame-coherent, glitch-filtered input image for the rest of the core CPLD. At each SGPIO frame boundary, marked by the master's load strobe, it takes a snapshot of the receive vector. The filtered output updates only after `MATCH_COUNT` consecutive identical frames. The block also flags which bits changed and detects a stalled SGPIO bus.

## Interface
- `TOTAL_INPUT_MODULES`, 3, number of 8-bit expander modules; W = TOTAL_INPUT_MODULES*8
- `MATCH_COUNT`, 3, consecutive identical frames required before update (legal 1..15)
- `TIMEOUT_CYCLES`, 2048, iClk cycles without a frame boundary before stall is flagged (≥2)
- `iClk  in  1  system clock (2 MHz)`
- `iRst  in  1  reset, synchronous, active-high`
- `iSLoad  in  1  SGPIO load strobe from master (asynchronous to iClk, idles high)`
- `ivDataIn  in  W  parallel receive vector from master`
- `ovDataFiltered  out  W  last accepted frame`
- `oValid  out  1  at least one frame accepted since reset`
- `oChangePulse  out  1  one-cycle pulse when ovDataFiltered updates`
- `ovChanged  out  W  XOR of previous and new ovDataFiltered, latched at update`
- `oStall  out  1  no frame boundary for TIMEOUT_CYCLES`

## Operation
- **Input synchronisation:**
  - iSLoad passes through a 2-flop synchroniser (reset value 1), then a delay flop (reset value 1).
  - ivDataIn is registered every cycle into rData.
- **Frame event (FE):** synchronised load = 0 while the delayed load = 1, i.e. the falling edge of the load strobe.
- **Filter state:** candidate register rCand (W bits, reset 0) and match counter rCnt (4 bits, reset 0).
- **On FE, with snapshot S = rData:**
  - If rCnt ≠ 0 and S == rCand: rCnt <= min(rCnt+1, MATCH_COUNT).
  - Otherwise: rCand <= S, rCnt <= 1.
  - Let N be the new rCnt value. If N == MATCH_COUNT and (S ≠ ovDataFiltered or oValid == 0):
    - ovDataFiltered <= S
    - ovChanged <= S ^ ovDataFiltered
    - oValid <= 1
    - oChangePulse <= 1
  - Frames identical to the current ovDataFiltered never pulse.
- **oChangePulse:** 0 on every cycle without an update.
- **ovChanged:** holds its value until the next update.
- **Stall timer:**
  - Counter width $clog2(TIMEOUT_CYCLES+1), reset 0.
  - Cleared on FE; otherwise increments and saturates at TIMEOUT_CYCLES.
  - oStall = 1 while the counter == TIMEOUT_CYCLES.
  - On the cycle the counter reaches TIMEOUT_CYCLES, rCnt <= 0. After a stall, a full MATCH_COUNT sequence is needed again.
  - ovDataFiltered and oValid are held through a stall.
- **Simultaneous FE and timeout:** FE wins. The timer clears, oStall deasserts, and rCnt is not zeroed.
- **Two-state FSM (internal):**
  - ACQUIRE (rCnt < MATCH_COUNT) → LOCKED on reaching MATCH_COUNT.
  - LOCKED → ACQUIRE on a mismatching FE (rCnt=1) or on stall.
- **Reset:** iRst asserted at any time, including mid-acquire, forces all registers and outputs to their reset values on the next iClk edge.

## Timing
- **Output reset values:** ovDataFiltered = 0, oValid = 0, oChangePulse = 0, ovChanged = 0, oStall = 0.
- **FE latency:** iSLoad falls before iClk edge k. The synchroniser captures it at k and k+1, so FE is asserted during the cycle between k+1 and k+2. State and outputs update at edge k+2, so the outputs are visible 3 edges after the iSLoad fall.
- **Snapshot timing:** S is the ivDataIn value sampled at edge k+1.
- **oChangePulse width:** exactly one iClk cycle.
- **Stall timing:** oStall asserts TIMEOUT_CYCLES edges after the FE edge. It deasserts on the edge where the next FE is processed.
- **Nominal frame rate:** at 100 kHz SClock and W=24, one FE every 480 iClk. The default timeout therefore covers about 4 frames.

## Test plan
- **Reset:** hold iRst 5 cycles with random ivDataIn and toggling iSLoad → all outputs 0; no oChangePulse after release until 3 FEs.
- **Acquire:** 3 frames with ivDataIn=0xA50F3C → after the 3rd FE (+3 edges): ovDataFiltered=0xA50F3C, oValid=1, ovChanged=0xA50F3C, oChangePulse high exactly 1 cycle. A 4th identical frame → no pulse.
- **Glitch rejection:** locked on 0xA50F3C.
  - Frames 0x000001, 0x000001, 0xA50F3C → no update.
  - Then 3× 0x000001 → ovDataFiltered=0x000001, ovChanged=0xA50F3D, one pulse.
- **Stall:** stop iSLoad toggling after an FE → oStall=1 exactly TIMEOUT_CYCLES edges later; ovDataFiltered held.
  - Resume with 2 frames of a new value → no update. Third frame → update.
  - oStall clears at the first resumed FE.
- **Reset mid-acquire:** 2 matching frames of 0x123456, then pulse iRst → counters cleared; 2 further frames → no update; 3rd → update with oValid=1.
- **MATCH_COUNT=1 build:** every FE with a new value updates on the same FE; repeated values give no pulse.

Source files
------------

// File: rtl/gsx_input_filter.sv
// rtl/gsx_input_filter.sv - frame-coherent glitch filter for the SGPIO receive vector
// Snapshots the receive vector on each load-strobe falling edge and accepts it after MATCH_COUNT identical frames.
module gsx_input_filter #(
  parameter int TOTAL_INPUT_MODULES = 3,
  parameter int MATCH_COUNT         = 3,
  parameter int TIMEOUT_CYCLES      = 2048
) (
  input  logic                               iClk,
  input  logic                               iRst,
  input  logic                               iSLoad,
  input  logic [TOTAL_INPUT_MODULES*8-1:0]   ivDataIn,
  output logic [TOTAL_INPUT_MODULES*8-1:0]   ovDataFiltered,
  output logic                               oValid,
  output logic                               oChangePulse,
  output logic [TOTAL_INPUT_MODULES*8-1:0]   ovChanged,
  output logic                               oStall
);

  localparam int W  = TOTAL_INPUT_MODULES * 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0]    MATCH_MAX   = 4'(MATCH_COUNT);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_PRE = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } filterState_t;

  filterState_t   rState;
  filterState_t   wNextState;

  logic [1:0]     rSLoadSync;
  logic           rSLoadDly;
  logic [W-1:0]   rData;
  logic [W-1:0]   rCand;
  logic [3:0]     rCnt;
  logic [TW-1:0]  rTimer;

  logic           wFe;
  logic           wMatch;
  logic           wTimeoutHit;
  logic           wUpdate;
  logic [3:0]     wCntInc;
  logic [3:0]     wCntNext;

  // Frame boundary is the falling edge of the synchronised load strobe.
  assign wFe         = rSLoadDly & ~rSLoadSync[1];
  assign wTimeoutHit = ~wFe && (rTimer == TIMEOUT_PRE);
  assign oStall      = (rTimer == TIMEOUT_MAX);

  always_comb begin
    wMatch     = (rCnt != 4'd0) && (rData == rCand);
    // LOCKED implies the counter already sits at MATCH_COUNT, so it saturates there.
    wCntInc    = (rState == LOCKED) ? MATCH_MAX : rCnt + 4'd1;
    wCntNext   = rCnt;
    wNextState = rState;
    wUpdate    = 1'b0;

    if (wFe) begin
      wCntNext   = wMatch ? wCntInc : 4'd1;
      wNextState = (wCntNext == MATCH_MAX) ? LOCKED : ACQUIRE;
      wUpdate    = (wCntNext == MATCH_MAX) && ((rData != ovDataFiltered) || ~oValid);
    end else if (wTimeoutHit) begin
      wCntNext   = 4'd0;
      wNextState = ACQUIRE;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rState <= ACQUIRE;
    end else begin
      rState <= wNextState;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rSLoadSync     <= 2'b11;
      rSLoadDly      <= 1'b1;
      rData          <= '0;
      rCand          <= '0;
      rCnt           <= 4'd0;
      rTimer         <= '0;
      ovDataFiltered <= '0;
      ovChanged      <= '0;
      oValid         <= 1'b0;
      oChangePulse   <= 1'b0;
    end else begin
      rSLoadSync   <= {rSLoadSync[0], iSLoad};
      rSLoadDly    <= rSLoadSync[1];
      rData        <= ivDataIn;
      rCnt         <= wCntNext;
      oChangePulse <= wUpdate;

      if (wFe && ~wMatch) begin
        rCand <= rData;
      end

      if (wUpdate) begin
        ovDataFiltered <= rData;
        ovChanged      <= rData ^ ovDataFiltered;
        oValid         <= 1'b1;
      end

      if (wFe) begin
        rTimer <= '0;
      end else if (rTimer != TIMEOUT_MAX) begin
        rTimer <= rTimer + 1'b1;
      end
    end
  end

endmodule
